// File: rtl/mem_streams_pkg.sv
// rtl/mem_streams_pkg.sv - shared state types and width helpers for the block-buffer sequencer
package mem_streams_pkg;

   typedef enum logic [1:0] {
      W_WAIT_SOF = 2'd0,
      W_FILL     = 2'd1,
      W_DROP     = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_BURST = 2'd1,
      R_GAP   = 2'd2
   } rd_state_t;

   // Width of a counter that must hold 0..max_blks inclusive.
   function automatic int cnt_w(input int max_blks);
      return $clog2(max_blks + 1);
   endfunction

   // Width of an index counting 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_streams_rd_sched.sv
// rtl/mem_streams_rd_sched.sv - read-burst scheduler and matured-block counter
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_rd_ready       : downstream can take one full burst (sampled in R_IDLE only)
//   i_blk_mature     : one-cycle token, a written block became readable
//   o_rd_ren         : buffer read enable, BLK_LEN consecutive cycles per burst
//   o_burst_done     : pulse on the last o_rd_ren of a burst
//   o_blk_cnt        : matured blocks not yet read
module mem_streams_rd_sched
   import mem_streams_pkg::*;
#(
   parameter int BLK_LEN  = 396,
   parameter int MAX_BLKS = 4,
   parameter int READ_GAP = 2,
   localparam int CNT_W   = cnt_w(MAX_BLKS)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_rd_ready,
   input  logic             i_blk_mature,
   output logic             o_rd_ren,
   output logic             o_burst_done,
   output logic [CNT_W-1:0] o_blk_cnt
);

   localparam int RC_W  = idx_w(BLK_LEN);
   localparam int GAP_W = idx_w(READ_GAP);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(BLK_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(READ_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BLKS);

   rd_state_t        state;
   logic [RC_W-1:0]  rcnt;
   logic [GAP_W-1:0] gcnt;
   logic             cnt_up;
   logic             cnt_dn;

   assign cnt_up = i_blk_mature;
   assign cnt_dn = o_burst_done && (o_blk_cnt != '0);

   // o_rd_ren and o_burst_done are registered copies of the burst state, so
   // the read window trails R_BURST by one cycle. The block count therefore
   // drops one cycle after the last read; R_GAP (>= 1 cycle) guarantees the
   // count is already updated when R_IDLE looks at it again.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= R_IDLE;
         rcnt         <= '0;
         gcnt         <= '0;
         o_rd_ren     <= 1'b0;
         o_burst_done <= 1'b0;
         o_blk_cnt    <= '0;
      end else begin
         o_rd_ren     <= (state == R_BURST);
         o_burst_done <= (state == R_BURST) && (rcnt == RC_LAST);

         if (cnt_up && !cnt_dn && (o_blk_cnt != CNT_MAX)) begin
            o_blk_cnt <= o_blk_cnt + 1'b1;
         end else if (cnt_dn && !cnt_up) begin
            o_blk_cnt <= o_blk_cnt - 1'b1;
         end

         case (state)
            R_IDLE: begin
               if (i_rd_ready && (o_blk_cnt != '0)) begin
                  state <= R_BURST;
                  rcnt  <= '0;
               end
            end
            R_BURST: begin
               if (rcnt == RC_LAST) begin
                  state <= R_GAP;
                  gcnt  <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            R_GAP: begin
               if (gcnt == GAP_LAST) begin
                  state <= R_IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_streams_ctrl.sv
// rtl/mem_streams_ctrl.sv - write/read sequencer for the multi-channel block buffer
// Ports:
//   i_clk, i_reset_n        : clock, async active-low reset (shared with the buffer)
//   i_in_valid, i_in_sof    : input word valid, first word of a block
//   i_rd_ready              : downstream can accept one full burst
//   o_wr_wen, o_wr_addr     : buffer write enable and running write word index
//   o_rd_ren, o_rvalid      : buffer read enable / read window (identical)
//   o_burst_done            : pulse on the last read of a burst
//   o_blk_cnt               : matured blocks not yet read
//   o_overflow, o_sof_err   : sticky error flags
module mem_streams_ctrl
   import mem_streams_pkg::*;
#(
   parameter int WADDR_WIDTH = 11,
   parameter int BLK_LEN     = 396,
   parameter int MAX_BLKS    = 4,
   parameter int READ_GAP    = 2,
   parameter int WR2RD_LAT   = 4,
   localparam int CNT_W      = cnt_w(MAX_BLKS)
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_in_valid,
   input  logic                   i_in_sof,
   input  logic                   i_rd_ready,
   output logic                   o_wr_wen,
   output logic [WADDR_WIDTH-1:0] o_wr_addr,
   output logic                   o_rd_ren,
   output logic                   o_rvalid,
   output logic                   o_burst_done,
   output logic [CNT_W-1:0]       o_blk_cnt,
   output logic                   o_overflow,
   output logic                   o_sof_err
);

   localparam int WC_W  = idx_w(BLK_LEN);
   localparam int OCC_W = CNT_W + $clog2(WR2RD_LAT + 1) + 1;
   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(BLK_LEN - 1);
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_BLKS);

   wr_state_t            wstate;
   logic [WC_W-1:0]      wcnt;
   logic [WR2RD_LAT-1:0] mature_dly;
   logic [OCC_W-1:0]     occupancy;
   logic                 room;
   logic                 wr_word;
   logic                 blk_done;

   // Blocks held in the buffer: matured-unread plus still-maturing. A fill in
   // progress never overlaps W_WAIT_SOF, the only place room is consulted.
   always_comb begin
      occupancy = OCC_W'(o_blk_cnt);
      for (int i = 0; i < WR2RD_LAT; i++) begin
         occupancy = occupancy + OCC_W'(mature_dly[i]);
      end
   end

   assign room     = (occupancy < OCC_MAX);
   assign wr_word  = ((wstate == W_WAIT_SOF) && i_in_valid && i_in_sof && room) ||
                     ((wstate == W_FILL) && i_in_valid);
   // In W_WAIT_SOF wcnt is 0, so a one-word block completes on its sof word.
   assign blk_done = wr_word && (wcnt == WC_LAST);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wstate     <= W_WAIT_SOF;
         wcnt       <= '0;
         mature_dly <= '0;
         o_wr_wen   <= 1'b0;
         o_wr_addr  <= '0;
         o_overflow <= 1'b0;
         o_sof_err  <= 1'b0;
      end else begin
         o_wr_wen <= wr_word;
         // The address shown with a write is that word's index; it steps on
         // the cycle after each write so back-to-back words stay contiguous.
         if (o_wr_wen) begin
            o_wr_addr <= o_wr_addr + 1'b1;
         end

         mature_dly[0] <= blk_done;
         for (int i = 1; i < WR2RD_LAT; i++) begin
            mature_dly[i] <= mature_dly[i-1];
         end

         case (wstate)
            W_WAIT_SOF: begin
               if (i_in_valid && i_in_sof) begin
                  if (!room) begin
                     o_overflow <= 1'b1;
                  end
                  if (BLK_LEN > 1) begin
                     wstate <= room ? W_FILL : W_DROP;
                     wcnt   <= WC_W'(1);
                  end
               end
            end
            W_FILL: begin
               if (i_in_valid) begin
                  // A stray sof is only flagged; the word stays part of this block.
                  if (i_in_sof) begin
                     o_sof_err <= 1'b1;
                  end
                  if (wcnt == WC_LAST) begin
                     wstate <= W_WAIT_SOF;
                     wcnt   <= '0;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            W_DROP: begin
               if (i_in_valid) begin
                  if (wcnt == WC_LAST) begin
                     wstate <= W_WAIT_SOF;
                     wcnt   <= '0;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            default: wstate <= W_WAIT_SOF;
         endcase
      end
   end

   mem_streams_rd_sched #(
      .BLK_LEN  (BLK_LEN),
      .MAX_BLKS (MAX_BLKS),
      .READ_GAP (READ_GAP)
   ) u_rd_sched (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_rd_ready   (i_rd_ready),
      .i_blk_mature (mature_dly[WR2RD_LAT-1]),
      .o_rd_ren     (o_rd_ren),
      .o_burst_done (o_burst_done),
      .o_blk_cnt    (o_blk_cnt)
   );

   assign o_rvalid = o_rd_ren;

endmodule

// File: tb/tb_mem_streams_ctrl.sv
// tb/tb_mem_streams_ctrl.sv - self-checking bench for mem_streams_ctrl against a timestamp model
module tb_mem_streams_ctrl;

   localparam int WAW  = 4;
   localparam int BLK  = 4;
   localparam int MB   = 2;
   localparam int GAP  = 2;
   localparam int LAT  = 4;
   localparam int CW   = 2;
   localparam int MAXC = 8192;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic i_in_valid = 1'b0;
   logic i_in_sof = 1'b0;
   logic i_rd_ready = 1'b0;
   logic o_wr_wen;
   logic [WAW-1:0] o_wr_addr;
   logic o_rd_ren;
   logic o_rvalid;
   logic o_burst_done;
   logic [CW-1:0] o_blk_cnt;
   logic o_overflow;
   logic o_sof_err;

   mem_streams_ctrl #(
      .WADDR_WIDTH (WAW),
      .BLK_LEN     (BLK),
      .MAX_BLKS    (MB),
      .READ_GAP    (GAP),
      .WR2RD_LAT   (LAT)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_in_valid   (i_in_valid),
      .i_in_sof     (i_in_sof),
      .i_rd_ready   (i_rd_ready),
      .o_wr_wen     (o_wr_wen),
      .o_wr_addr    (o_wr_addr),
      .o_rd_ren     (o_rd_ren),
      .o_rvalid     (o_rvalid),
      .o_burst_done (o_burst_done),
      .o_blk_cnt    (o_blk_cnt),
      .o_overflow   (o_overflow),
      .o_sof_err    (o_sof_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   bit rel_pending = 1'b0;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Timestamp model: future events are scheduled into per-cycle arrays.
   bit m_wen [MAXC];
   bit m_ren [MAXC];
   bit m_done[MAXC];
   int m_mat [MAXC];
   int m_dec [MAXC];
   int m_push[MAXC];
   int m_blk, m_pushed, m_decs, m_addr, m_wmode, m_wc;
   int m_ovf_at, m_sof_at, m_idle_from;

   int first_wen, first_cnt1, first_done, n_wen;
   int q_rise[$];
   int q_fall[$];
   logic prev_ren;

   task automatic model_clear(input int from);
      for (int i = from; i < MAXC; i++) begin
         m_wen[i] = 0; m_ren[i] = 0; m_done[i] = 0;
         m_mat[i] = 0; m_dec[i] = 0; m_push[i] = 0;
      end
      m_blk = 0; m_pushed = 0; m_decs = 0; m_addr = 0; m_wmode = 0; m_wc = 0;
      m_ovf_at = 2 * MAXC; m_sof_at = 2 * MAXC; m_idle_from = 0;
   endtask

   task automatic mon_clear();
      first_wen = -1; first_cnt1 = -1; first_done = -1; n_wen = 0;
      q_rise.delete(); q_fall.delete(); prev_ren = 1'b0;
   endtask

   task automatic check_cycle();
      int t;
      t = cyc;
      m_blk    += m_mat[t] - m_dec[t];
      m_decs   += m_dec[t];
      m_pushed += m_push[t];
      chk_eq("wr_wen",     int'(o_wr_wen),     int'(m_wen[t]));
      chk_eq("wr_addr",    int'(o_wr_addr),    m_addr % (1 << WAW));
      chk_eq("rd_ren",     int'(o_rd_ren),     int'(m_ren[t]));
      chk_eq("rvalid",     int'(o_rvalid),     int'(m_ren[t]));
      chk_eq("burst_done", int'(o_burst_done), int'(m_done[t]));
      chk_eq("blk_cnt",    int'(o_blk_cnt),    m_blk);
      chk_eq("overflow",   int'(o_overflow),   int'(t >= m_ovf_at));
      chk_eq("sof_err",    int'(o_sof_err),    int'(t >= m_sof_at));
      if (m_wen[t]) m_addr++;
      if (o_wr_wen) begin
         n_wen++;
         if (first_wen < 0) first_wen = t;
      end
      if (o_blk_cnt == 2'd1 && first_cnt1 < 0) first_cnt1 = t;
      if (o_burst_done && first_done < 0) first_done = t;
      if (o_rd_ren && !prev_ren) q_rise.push_back(t);
      if (!o_rd_ren && prev_ren) q_fall.push_back(t);
      prev_ren = o_rd_ren;
   endtask

   task automatic model_step();
      int t, occ;
      t = cyc;
      occ = m_pushed - m_decs;
      if (i_in_valid) begin
         case (m_wmode)
            0: if (i_in_sof) begin
                  if (occ < MB) begin
                     m_wmode = 1;
                     m_wen[t+1] = 1;
                  end else begin
                     m_wmode = 2;
                     if (m_ovf_at > t + 1) m_ovf_at = t + 1;
                  end
                  m_wc = 1;
               end
            1: begin
                  if (i_in_sof && m_sof_at > t + 1) m_sof_at = t + 1;
                  m_wen[t+1] = 1;
                  m_wc++;
                  if (m_wc == BLK) begin
                     m_wmode = 0; m_wc = 0;
                     m_push[t+1]++;
                     m_mat[t+1+LAT]++;
                  end
               end
            default: begin
                  m_wc++;
                  if (m_wc == BLK) begin m_wmode = 0; m_wc = 0; end
               end
         endcase
      end
      if (t >= m_idle_from && m_blk > 0 && i_rd_ready) begin
         for (int k = 2; k <= BLK + 1; k++) m_ren[t+k] = 1;
         m_done[t+1+BLK] = 1;
         m_dec[t+2+BLK]++;
         m_idle_from = t + BLK + GAP + 1;
      end
   endtask

   task automatic step(input logic v, input logic s, input logic r);
      @(posedge i_clk);
      cyc++;
      if (cyc > MAXC - 64) begin
         $display("FAIL cycle_budget: reached %0d, limit %0d", cyc, MAXC - 64);
         $fatal(1);
      end
      #1;
      if (rel_pending) begin
         i_reset_n = 1'b1;
         rel_pending = 1'b0;
      end
      i_in_valid = v; i_in_sof = s; i_rd_ready = r;
      @(negedge i_clk);
      check_cycle();
      model_step();
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      cyc++;
      #1;
      i_reset_n = 1'b0; i_in_valid = 1'b0; i_in_sof = 1'b0;
      #1;
      chk_eq("rst_rd_ren",     int'(o_rd_ren),     0);
      chk_eq("rst_burst_done", int'(o_burst_done), 0);
      chk_eq("rst_blk_cnt",    int'(o_blk_cnt),    0);
      chk_eq("rst_wr_addr",    int'(o_wr_addr),    0);
      chk_eq("rst_wr_wen",     int'(o_wr_wen),     0);
      chk_eq("rst_overflow",   int'(o_overflow),   0);
      chk_eq("rst_sof_err",    int'(o_sof_err),    0);
      repeat (2) begin
         @(posedge i_clk);
         cyc++;
      end
      rel_pending = 1'b1;
      model_clear(cyc + 1);
      mon_clear();
   endtask

   initial begin
      #(MAXC * 10);
      $display("FAIL watchdog: time limit %0d ns reached", MAXC * 10);
      $fatal(1);
   end

   initial begin
      int t0;
      logic r;

      // Single block, downstream always ready: latency chain end to end.
      do_reset();
      step(0, 0, 1); step(0, 0, 1);
      t0 = cyc + 1;
      step(1, 1, 1);
      repeat (3) step(1, 0, 1);
      repeat (16) step(0, 0, 1);
      chk_eq("p1_first_wen",  first_wen - t0, 1);
      chk_eq("p1_cnt1_at",    first_cnt1 - t0, 8);
      chk_eq("p1_ren_rise",   (q_rise.size() > 0) ? q_rise[0] - t0 : -1, 10);
      chk_eq("p1_ren_fall",   (q_fall.size() > 0) ? q_fall[0] - t0 : -1, 14);
      chk_eq("p1_done_at",    first_done - t0, 13);
      chk_eq("p1_blk_cnt_end", int'(o_blk_cnt), 0);

      // Three back-to-back blocks with reads held off: third one overflows.
      do_reset();
      for (int b = 0; b < 3; b++) begin
         step(1, 1, 0);
         repeat (3) step(1, 0, 0);
      end
      repeat (10) step(0, 0, 0);
      chk_eq("p2_blk_cnt",  int'(o_blk_cnt), 2);
      chk_eq("p2_overflow", int'(o_overflow), 1);
      chk_eq("p2_n_wen",    n_wen, 8);
      chk_eq("p2_wr_addr",  int'(o_wr_addr), 8);
      // Drain: ready toggles freely while a burst or gap is in progress.
      for (int i = 0; i < 30; i++) begin
         r = (cyc + 1 < m_idle_from) ? 1'($urandom_range(0, 1)) : 1'b1;
         step(0, 0, r);
      end
      chk_eq("p2_bursts",     q_rise.size(), 2);
      chk_eq("p2_burst0_len", (q_fall.size() > 0) ? q_fall[0] - q_rise[0] : -1, BLK);
      chk_eq("p2_idle_gap",   (q_rise.size() > 1) ? q_rise[1] - q_fall[0] : -1, GAP + 1);
      chk_eq("p2_burst1_len", (q_fall.size() > 1) ? q_fall[1] - q_rise[1] : -1, BLK);
      chk_eq("p2_blk_cnt_end", int'(o_blk_cnt), 0);

      // Words before any sof are discarded.
      do_reset();
      repeat (3) step(1, 0, 1);
      t0 = cyc + 1;
      step(1, 1, 1);
      repeat (3) step(1, 0, 1);
      repeat (12) step(0, 0, 1);
      chk_eq("p3_first_wen", first_wen - t0, 1);
      chk_eq("p3_n_wen",     n_wen, BLK);

      // Stray sof mid-block: flagged, still written, block still counted.
      do_reset();
      step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
      repeat (10) step(0, 0, 0);
      chk_eq("p4_sof_err", int'(o_sof_err), 1);
      chk_eq("p4_n_wen",   n_wen, BLK);
      chk_eq("p4_blk_cnt", int'(o_blk_cnt), 1);

      // Reset asserted in the middle of a burst clears everything at once.
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1);
         if (o_rd_ren) break;
      end
      chk_eq("p5_in_burst", int'(o_rd_ren), 1);
      do_reset();

      // Randomised traffic, with one reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         logic v, s;
         if (i == 750) do_reset();
         v = ($urandom_range(0, 9) < 7);
         s = v && ($urandom_range(0, 4) == 0);
         r = ($urandom_range(0, 2) != 0);
         step(v, s, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
